// File: rtl/snes_poll_scheduler.sv
// -----------------------------------------------------------------------------
// snes_poll_scheduler
//
// Periodically (or on request) runs one SNES controller read sequence and
// exposes the captured pad words, a "new data" flag and a poll counter to a
// simple CPU read port.
//
// Sequence per poll:
//   START : latch pulse to the SNES interface (addr 2'b10), restart the period
//   BUSY  : wait BUSY_CYCLES clocks while the interface shifts the pads in
//   RD0   : read pad 0 word (addr 2'b00)
//   RD1   : read pad 1 word (addr 2'b01), capture pad 0 (one-cycle read latency)
//   CAP1  : capture pad 1, raise new_flag, bump poll_cnt
//
// Ports
//   clk          in   system clock (12.5 MHz), only clock of the block
//   rst          in   synchronous active-high reset
//   tick_count   in   free-running 100 us tick count from the timer
//   timer_read   out  timer latch/read enable, 1 outside reset
//   snes_rd_en   out  SNES interface read enable
//   snes_addr    out  SNES interface address
//   snes_rd_data in   SNES interface read data, valid one cycle after snes_rd_en
//   enable       in   allow periodic polling
//   poll_req     in   one-cycle request for an immediate poll
//   cpu_req      in   one-cycle CPU read strobe
//   cpu_addr     in   CPU register select: 0 pad0, 1 pad1, 2 new_flag, 3 poll_cnt
//   cpu_ack      out  one-cycle acknowledge, the cycle after cpu_req
//   cpu_data     out  read data, held between reads
// -----------------------------------------------------------------------------
module snes_poll_scheduler #(
   parameter int POLL_TICKS  = 167,
   parameter int BUSY_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] tick_count,
   output logic        timer_read,
   output logic        snes_rd_en,
   output logic [1:0]  snes_addr,
   input  logic [11:0] snes_rd_data,
   input  logic        enable,
   input  logic        poll_req,
   input  logic        cpu_req,
   input  logic [1:0]  cpu_addr,
   output logic        cpu_ack,
   output logic [11:0] cpu_data
);

   localparam int          BW        = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
   localparam logic [BW-1:0] BUSY_INIT = BW'(BUSY_CYCLES - 1);
   localparam logic [15:0] POLL_W    = 16'(POLL_TICKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_RD0,
      S_RD1,
      S_CAP1
   } state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] busy_cnt;
   logic [15:0]   last_poll;
   logic [15:0]   elapsed;
   logic          pending;
   logic          due;
   logic [11:0]   pad0, pad1;
   logic          new_flag;
   logic [11:0]   poll_cnt;

   // Modulo-2^16 difference: a tick_count wrap does not shorten or stretch
   // the poll period.
   assign elapsed = tick_count - last_poll;
   assign due     = (enable && (elapsed >= POLL_W)) || pending;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, exactly like the hardware.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Next state and SNES interface outputs
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      snes_rd_en = 1'b0;
      snes_addr  = 2'b00;
      case (state)
         S_IDLE: begin
            if (due) state_nxt = S_START;
         end
         S_START: begin
            snes_rd_en = 1'b1;
            snes_addr  = 2'b10;
            state_nxt  = S_BUSY;
         end
         S_BUSY: begin
            if (busy_cnt == '0) state_nxt = S_RD0;
         end
         S_RD0: begin
            snes_rd_en = 1'b1;
            snes_addr  = 2'b00;
            state_nxt  = S_RD1;
         end
         S_RD1: begin
            snes_rd_en = 1'b1;
            snes_addr  = 2'b01;
            state_nxt  = S_CAP1;
         end
         S_CAP1: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Poll bookkeeping and pad capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_read <= 1'b0;
         last_poll  <= '0;
         pending    <= 1'b0;
         busy_cnt   <= '0;
         pad0       <= '0;
         pad1       <= '0;
         poll_cnt   <= '0;
      end else begin
         timer_read <= 1'b1;

         // Entering START consumes the request. A poll_req in that same cycle
         // is merged into the poll being started, so a coincident request and
         // periodic due yield a single poll.
         if (state == S_IDLE && due) pending <= 1'b0;
         else if (poll_req)          pending <= 1'b1;

         case (state)
            S_START: begin
               last_poll <= tick_count;
               busy_cnt  <= BUSY_INIT;
            end
            S_BUSY: begin
               if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            end
            S_RD1:  pad0 <= snes_rd_data;
            S_CAP1: begin
               pad1     <= snes_rd_data;
               poll_cnt <= poll_cnt + 12'd1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // CPU read port (independent of the FSM, no backpressure)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         new_flag <= 1'b0;
         cpu_ack  <= 1'b0;
         cpu_data <= '0;
      end else begin
         // Capture sets the flag with priority over a clearing read.
         if (state == S_CAP1)                   new_flag <= 1'b1;
         else if (cpu_req && cpu_addr == 2'd2)  new_flag <= 1'b0;

         cpu_ack <= cpu_req;
         // Registers are read before this edge's captures land, so a read
         // coinciding with a capture returns the old value.
         if (cpu_req) begin
            case (cpu_addr)
               2'd0:    cpu_data <= pad0;
               2'd1:    cpu_data <= pad1;
               2'd2:    cpu_data <= {11'b0, new_flag};
               default: cpu_data <= poll_cnt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snes_poll_scheduler.sv
`timescale 1ns/1ps
module tb_snes_poll_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tick_count;
   logic        timer_read;
   logic        snes_rd_en;
   logic [1:0]  snes_addr;
   logic [11:0] snes_rd_data;
   logic        enable;
   logic        poll_req;
   logic        cpu_req;
   logic [1:0]  cpu_addr;
   logic        cpu_ack;
   logic [11:0] cpu_data;

   snes_poll_scheduler #(.POLL_TICKS(167), .BUSY_CYCLES(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_count   (tick_count),
      .timer_read   (timer_read),
      .snes_rd_en   (snes_rd_en),
      .snes_addr    (snes_addr),
      .snes_rd_data (snes_rd_data),
      .enable       (enable),
      .poll_req     (poll_req),
      .cpu_req      (cpu_req),
      .cpu_addr     (cpu_addr),
      .cpu_ack      (cpu_ack),
      .cpu_data     (cpu_data)
   );

   always #40 clk = ~clk;   // 12.5 MHz

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q[$];       // expected CPU read data, in issue order
   logic [15:0] start_ticks[$]; // tick_count seen in each START cycle
   int          start_total = 0;
   int          rd0_cnt     = 0;
   int          pulse_bad   = 0;
   logic        prev_start  = 1'b0;

   // SNES interface model: pad words presented one cycle after the read.
   logic [11:0] pad0_val = 12'h000;
   logic [11:0] pad1_val = 12'h000;
   logic [11:0] snes_nxt = 12'h777;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard for CPU reads plus START / RD0 logging.
   always @(negedge clk) begin
      if (cpu_ack) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cpu_ack_unexpected: got data %0h expected no ack", cpu_data);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            if (cpu_data !== e) begin
               bad++;
               $display("FAIL cpu_read: got %0h expected %0h", cpu_data, e);
            end
         end
      end
      if (snes_rd_en && snes_addr == 2'b10) begin
         start_ticks.push_back(tick_count);
         start_total++;
         if (prev_start) pulse_bad++;
      end
      prev_start = snes_rd_en && snes_addr == 2'b10;
      if (snes_rd_en && snes_addr == 2'b00) rd0_cnt++;
      if (snes_rd_en && snes_addr == 2'b00)      snes_nxt = pad0_val;
      else if (snes_rd_en && snes_addr == 2'b01) snes_nxt = pad1_val;
      else                                       snes_nxt = 12'h777;
   end

   always @(posedge clk) begin
      #1 snes_rd_data = snes_nxt;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [1:0] a, input logic [11:0] exp);
      exp_q.push_back(exp);
      cpu_req  = 1'b1;
      cpu_addr = a;
      step();
      cpu_req  = 1'b0;
   endtask

   task automatic pulse_poll();
      poll_req = 1'b1;
      step();
      poll_req = 1'b0;
   endtask

   // Advance until the SNES interface is driven with the given address.
   task automatic wait_for(input logic [1:0] a, input int budget, input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         if (snes_rd_en && snes_addr == a) found = 1'b1;
         else step();
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL %s: got timeout expected snes_addr %0d", name, a);
      end
   endtask

   initial begin
      #1600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst          = 1'b1;
      tick_count   = 16'd0;
      snes_rd_data = 12'h777;
      enable       = 1'b0;
      poll_req     = 1'b0;
      cpu_req      = 1'b0;
      cpu_addr     = 2'd0;

      // Reset state
      repeat (3) step();
      check("rst_timer_read", timer_read, 0);
      check("rst_rd_en", snes_rd_en, 0);
      check("rst_addr", snes_addr, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_cpu_data", cpu_data, 0);
      rst = 1'b0;
      step();
      step();
      check("timer_read_on", timer_read, 1);
      cpu_read(2'd0, 12'h000);
      cpu_read(2'd1, 12'h000);
      cpu_read(2'd2, 12'h000);
      cpu_read(2'd3, 12'h000);

      // Pad capture, and a new_flag read colliding with CAP1
      pad0_val = 12'hA5C;
      pad1_val = 12'h3F0;
      pulse_poll();
      wait_for(2'b01, 100, "wait_rd1_a");
      step();                         // now in CAP1
      cpu_read(2'd2, 12'h000);        // set wins, old value returned
      cpu_read(2'd2, 12'h001);
      cpu_read(2'd2, 12'h000);
      cpu_read(2'd0, 12'hA5C);
      cpu_read(2'd1, 12'h3F0);
      cpu_read(2'd3, 12'h001);

      // Reset during BUSY aborts the sequence
      pad0_val = 12'h111;
      pad1_val = 12'h222;
      pulse_poll();
      wait_for(2'b10, 10, "wait_start_b");
      repeat (5) step();
      rst = 1'b1;
      step();
      check("abort_rd_en", snes_rd_en, 0);
      check("abort_addr", snes_addr, 0);
      check("abort_cpu_ack", cpu_ack, 0);
      check("abort_cpu_data", cpu_data, 0);
      check("abort_timer_read", timer_read, 0);
      rst  = 1'b0;
      base = rd0_cnt;
      repeat (100) step();
      check("abort_no_rd0", rd0_cnt - base, 0);
      cpu_read(2'd0, 12'h000);
      cpu_read(2'd1, 12'h000);
      cpu_read(2'd2, 12'h000);
      cpu_read(2'd3, 12'h000);

      // Periodic polling over tick_count 0..400
      pad0_val = 12'h5A5;
      pad1_val = 12'h0F0;
      start_ticks.delete();
      base   = start_total;
      enable = 1'b1;
      for (int t = 0; t <= 400; t++) begin
         tick_count = 16'(t);
         repeat (8) step();
      end
      enable = 1'b0;
      check("periodic_count", start_total - base, 2);
      if (start_ticks.size() >= 2) begin
         check("periodic_first", start_ticks[0], 167);
         check("periodic_second", start_ticks[1], 334);
      end
      check("start_pulse_width", pulse_bad, 0);
      cpu_read(2'd3, 12'd2);

      // Period across tick_count wrap: last_poll=65500
      tick_count = 16'd65500;
      pulse_poll();
      repeat (80) step();
      start_ticks.delete();
      enable = 1'b1;
      for (int k = 1; k <= 167; k++) begin
         tick_count = 16'(65500 + k);
         repeat (8) step();
      end
      enable = 1'b0;
      repeat (80) step();
      check("wrap_count", start_ticks.size(), 1);
      if (start_ticks.size() >= 1) check("wrap_tick", start_ticks[0], 131);
      cpu_read(2'd3, 12'd4);

      // poll_req during BUSY, twice: one extra poll
      pad0_val = 12'h123;
      pad1_val = 12'h456;
      base = start_total;
      pulse_poll();
      wait_for(2'b10, 10, "wait_start_c");
      repeat (5) step();
      pulse_poll();
      repeat (3) step();
      pulse_poll();
      repeat (200) step();
      check("busy_req_polls", start_total - base, 2);
      cpu_read(2'd3, 12'd6);
      cpu_read(2'd0, 12'h123);
      cpu_read(2'd1, 12'h456);

      // Reads coinciding with pad captures return pre-capture values
      pad0_val = 12'h789;
      pad1_val = 12'hABC;
      pulse_poll();
      wait_for(2'b00, 100, "wait_rd0_d");
      step();                         // now in RD1
      cpu_read(2'd0, 12'h123);        // issued in RD1
      cpu_read(2'd1, 12'h456);        // issued in CAP1
      repeat (3) step();
      cpu_read(2'd0, 12'h789);
      cpu_read(2'd1, 12'hABC);
      cpu_read(2'd3, 12'd7);

      // Simultaneous poll_req and periodic due: exactly one poll
      base       = start_total;
      enable     = 1'b1;
      tick_count = 16'd331;           // last_poll is 131, elapsed 200
      pulse_poll();
      repeat (150) step();
      enable = 1'b0;
      check("coincident_polls", start_total - base, 1);
      cpu_read(2'd3, 12'd8);

      repeat (3) step();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snes_poll_scheduler.md
SNES_POLL_SCHEDULER -- requirements
Module: snes_poll_scheduler

Interface
REQ-001 Parameter: POLL_TICKS, default 167, poll period in 100us timer ticks (about 16.7ms).
REQ-002 Parameter: BUSY_CYCLES, default 64, clk cycles reserved for one SNES latch/shift sequence.
REQ-003 clk  in  1  system clock, 12.5MHz; the block uses this single clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 tick_count  in  16  free-running 100us count from the timer's count_out.
REQ-006 timer_read  out  1  drives the timer's read (latch) input.
REQ-007 snes_rd_en  out  1  drives the SNES interface read_enable.
REQ-008 snes_addr  out  2  drives the SNES interface address.
REQ-009 snes_rd_data  in  12  SNES interface read_data, valid one cycle after snes_rd_en.
REQ-010 enable  in  1  allows periodic polling when 1.
REQ-011 poll_req  in  1  single-cycle pulse requesting an immediate poll.
REQ-012 cpu_req  in  1  single-cycle CPU read strobe.
REQ-013 cpu_addr  in  2  CPU register select.
REQ-014 cpu_ack  out  1  one-cycle read acknowledge.
REQ-015 cpu_data  out  12  CPU read data, valid while cpu_ack=1.

Function
REQ-016 timer_read SHALL be 1 in every cycle except reset cycles.
REQ-017 elapsed SHALL be tick_count minus last_poll, computed modulo 2^16, so wrap-around of tick_count does not disturb the period.
REQ-018 A poll is due when enable=1 and elapsed >= POLL_TICKS, or when the pending flag is set.
REQ-019 pending SHALL be set by poll_req in any state, and cleared on entry to START.
REQ-020 FSM states: IDLE, START, BUSY, RD0, RD1, CAP1.
REQ-021 IDLE -> START when a poll is due. Otherwise the FSM stays in IDLE.
REQ-022 START: drive snes_rd_en=1 and snes_addr=2'b10 for exactly one cycle, load last_poll<=tick_count, load busy counter<=BUSY_CYCLES-1, then go to BUSY.
REQ-023 BUSY: decrement the busy counter each cycle; go to RD0 in the cycle after it reads 0.
REQ-024 RD0: drive snes_rd_en=1 and snes_addr=2'b00, then go to RD1.
REQ-025 RD1: drive snes_rd_en=1 and snes_addr=2'b01, capture pad0<=snes_rd_data, then go to CAP1.
REQ-026 CAP1: capture pad1<=snes_rd_data, set new_flag, increment poll_cnt (12 bits, wraps 4095->0), then go to IDLE.
REQ-027 In all states other than START, RD0 and RD1, snes_rd_en=0 and snes_addr=2'b00.
REQ-028 A poll_req or due condition arising during START through CAP1 SHALL NOT abort the sequence. poll_req is held in pending; a periodic due is re-evaluated in IDLE.
REQ-029 Simultaneous poll_req and periodic due SHALL produce exactly one poll.
REQ-030 CPU read: cpu_req in cycle t gives cpu_ack=1 with cpu_data in cycle t+1. The CPU path is independent of the FSM state, and there is no backpressure.
REQ-031 cpu_addr map: 0 = pad0; 1 = pad1; 2 = {11'b0, new_flag}; 3 = poll_cnt.
REQ-032 A CPU read of address 2 SHALL clear new_flag. If CAP1 sets new_flag in the same cycle, set wins and the read returns the old value.
REQ-033 A CPU read in the same cycle a pad register is captured SHALL return the pre-capture value.
REQ-034 cpu_data SHALL hold its last value while cpu_ack=0.
REQ-035 enable=0 SHALL suppress periodic polls only; poll_req still triggers a poll.

Reset
REQ-036 On rst: FSM<=IDLE; snes_rd_en, snes_addr, timer_read, cpu_ack and cpu_data <=0.
REQ-037 On rst: pad0, pad1, new_flag, poll_cnt, last_poll, pending and the busy counter <=0.
REQ-038 rst mid-sequence SHALL abort immediately without capturing pad data. The SNES interface is reset by the same rst.

Verification
REQ-039 Scenario: enable=1, tick_count stepping 0..400 -> START in the cycles where tick_count=167 and tick_count=334; snes_addr=2'b10 pulse one cycle wide.
REQ-040 Scenario: last_poll=65500, tick_count wraps to 130 -> poll at tick_count=131 (elapsed=167), not earlier.
REQ-041 Scenario: snes_rd_data=12'hA5C in the RD1 cycle and 12'h3F0 in the CAP1 cycle -> cpu_addr 0 reads 12'hA5C, cpu_addr 1 reads 12'h3F0, cpu_addr 3 reads 1.
REQ-042 Scenario: poll_req during BUSY plus a second poll_req -> exactly one extra poll after CAP1, poll_cnt +2 total.
REQ-043 Scenario: cpu_req addr 2 in the same cycle as CAP1 -> cpu_data=0, then a following read returns 1, then a subsequent read returns 0.
REQ-044 Scenario: rst asserted during BUSY -> next cycle all outputs 0, FSM in IDLE, pads unchanged at 0, no RD0.
